apb_mem_arbiter: RTL

Two-requester APB master that shares the single APB memory slave (apbMem) between two on-chip clients. Performs round-robin arbitration, then runs a standard APB SETUP/ACCESS transfer, and drives the slave's PWAIT wait-state control from the granted requester's setting. Returns read data, a one-cycle acknowledge and an error flag to the granted requester. Includes a timeout so a stalled slave cannot lock the bus.

---
 rtl/apb_mem_arbiter_pkg.sv | 35 +++
 rtl/apb_mem_arbiter_if.sv | 35 +++
 rtl/apb_mem_arbiter_rr_arb2.sv | 34 +++
 rtl/apb_mem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// apb_mem_pkg
// Shared definitions for the two-requester APB memory arbiter.
//   apb_state_e : transfer FSM states (IDLE / SETUP / ACCESS)
//   DEF_*       : default widths and timeout used by the interface and top
//   rr_pick     : two-way round-robin pick, returns a one-hot grant
// ---------------------------------------------------------------------------
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_WAIT_W  = 4;
  localparam int DEF_TIMEOUT = 64;

  // A lone requester always wins. When both ask, 'prio' names the one
  // that was not granted last time (0 = m0, 1 = m1).
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic prio);
    logic [1:0] grant;
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    return grant;
  endfunction

endpackage

// File: rtl/apb_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_mem_arbiter_if
// APB bus between the arbiter (master) and the apbMem slave.
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PWAIT : master -> slave
//   PREADY, PRDATA                             : slave -> master
// PWAIT tells the slave how many wait states to insert.
// ---------------------------------------------------------------------------
interface apb_mem_arbiter_if
  import apb_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int WAIT_W = DEF_WAIT_W
);

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [WAIT_W-1:0] PWAIT;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PWAIT,
    input  PREADY, PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PWAIT,
    output PREADY, PRDATA
  );

endinterface

// File: rtl/apb_mem_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_req      : request vector, bit 0 = m0, bit 1 = m1
//   i_advance  : a grant is being taken this cycle, move the pointer
//   o_grant    : one-hot grant (combinational from i_req and pointer)
// After reset the pointer favours m0.
// ---------------------------------------------------------------------------
module rr_arb2
  import apb_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  logic r_prio;

  assign o_grant = rr_pick(i_req, r_prio);

  // Granting m0 hands priority to m1 and vice versa, so o_grant[0]
  // is exactly the new pointer value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (i_advance && (|o_grant)) begin
      r_prio <= o_grant[0];
    end
  end

endmodule

// File: rtl/apb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// apb_mem_arbiter
// Shares one APB memory slave between two requesters (m0, m1) with
// round-robin arbitration, a standard SETUP/ACCESS transfer, per-requester
// wait-state control and an ACCESS timeout.
//   PCLK, PRESET          : clock (rising edge), async active-low reset
//   mX_req/write/addr/
//   wdata/wait            : requester X transfer request (held until ack)
//   mX_ack/err/rdata      : one-cycle completion pulse, timeout flag,
//                           read data held until the next ack to X
//   apb (master modport)  : APB bus to the slave, including PWAIT
// ---------------------------------------------------------------------------
module apb_mem_arbiter
  import apb_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int WAIT_W  = DEF_WAIT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              PCLK,
  input  logic              PRESET,

  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [WAIT_W-1:0] m0_wait,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [WAIT_W-1:0] m1_wait,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,

  apb_mem_arbiter_if.master apb
);

  localparam int                CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_e        r_state,   w_nxtState;
  logic              r_psel,    w_nxtPsel;
  logic              r_penable, w_nxtPenable;
  logic              r_pwrite,  w_nxtPwrite;
  logic [ADDR_W-1:0] r_paddr,   w_nxtPaddr;
  logic [DATA_W-1:0] r_pwdata,  w_nxtPwdata;
  logic [WAIT_W-1:0] r_pwait,   w_nxtPwait;
  logic              r_owner,   w_nxtOwner;
  logic [CNT_W-1:0]  r_cnt,     w_nxtCnt;
  logic [1:0]        r_ack,     w_nxtAck;
  logic [1:0]        r_err,     w_nxtErr;
  logic [DATA_W-1:0] r_rdata0,  w_nxtRdata0;
  logic [DATA_W-1:0] r_rdata1,  w_nxtRdata1;

  logic [1:0]        w_eligible;
  logic [1:0]        w_grant;
  logic              w_advance;

  // A requester that is being acked this cycle still has req high; masking
  // it stops the same request from being served twice.
  assign w_eligible = {m1_req & ~r_ack[1], m0_req & ~r_ack[0]};
  assign w_advance  = (r_state == IDLE) && (|w_eligible);

  rr_arb2 u_arb (
    .clk       (PCLK),
    .rst_n     (PRESET),
    .i_req     (w_eligible),
    .i_advance (w_advance),
    .o_grant   (w_grant)
  );

  // Next-state and next-output logic. All bus and requester outputs are
  // registered, so this block computes their values for the next edge.
  always_comb begin
    w_nxtState   = r_state;
    w_nxtPsel    = r_psel;
    w_nxtPenable = r_penable;
    w_nxtPwrite  = r_pwrite;
    w_nxtPaddr   = r_paddr;
    w_nxtPwdata  = r_pwdata;
    w_nxtPwait   = r_pwait;
    w_nxtOwner   = r_owner;
    w_nxtCnt     = r_cnt;
    w_nxtAck     = 2'b00;
    w_nxtErr     = 2'b00;
    w_nxtRdata0  = r_rdata0;
    w_nxtRdata1  = r_rdata1;

    case (r_state)
      IDLE: begin
        w_nxtPsel    = 1'b0;
        w_nxtPenable = 1'b0;
        w_nxtPwrite  = 1'b0;
        w_nxtPaddr   = '0;
        w_nxtPwdata  = '0;
        w_nxtPwait   = '0;
        if (|w_eligible) begin
          w_nxtOwner = w_grant[1];
          w_nxtPsel  = 1'b1;
          w_nxtState = SETUP;
          if (w_grant[1]) begin
            w_nxtPwrite = m1_write;
            w_nxtPaddr  = m1_addr;
            w_nxtPwdata = m1_wdata;
            w_nxtPwait  = m1_wait;
          end else begin
            w_nxtPwrite = m0_write;
            w_nxtPaddr  = m0_addr;
            w_nxtPwdata = m0_wdata;
            w_nxtPwait  = m0_wait;
          end
        end
      end

      SETUP: begin
        w_nxtPenable = 1'b1;
        w_nxtCnt     = '0;
        w_nxtState   = ACCESS;
      end

      ACCESS: begin
        if (apb.PREADY) begin
          w_nxtPsel           = 1'b0;
          w_nxtPenable        = 1'b0;
          w_nxtPwait          = '0;
          w_nxtAck[r_owner]   = 1'b1;
          w_nxtState          = IDLE;
          if (!r_pwrite) begin
            if (r_owner) w_nxtRdata1 = apb.PRDATA;
            else         w_nxtRdata0 = apb.PRDATA;
          end
        end else if (r_cnt == CNT_LAST) begin
          // Slave never answered: abort so the other requester is not
          // locked out, and flag the owner with err and zeroed rdata.
          w_nxtPsel           = 1'b0;
          w_nxtPenable        = 1'b0;
          w_nxtPwait          = '0;
          w_nxtAck[r_owner]   = 1'b1;
          w_nxtErr[r_owner]   = 1'b1;
          w_nxtState          = IDLE;
          if (r_owner) w_nxtRdata1 = '0;
          else         w_nxtRdata0 = '0;
        end else begin
          w_nxtCnt = r_cnt + 1'b1;
        end
      end

      default: begin
        w_nxtState   = IDLE;
        w_nxtPsel    = 1'b0;
        w_nxtPenable = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset drops the bus immediately and
  // discards any transfer in flight without an ack.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      r_state   <= IDLE;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pwait   <= '0;
      r_owner   <= 1'b0;
      r_cnt     <= '0;
      r_ack     <= 2'b00;
      r_err     <= 2'b00;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_state   <= w_nxtState;
      r_psel    <= w_nxtPsel;
      r_penable <= w_nxtPenable;
      r_pwrite  <= w_nxtPwrite;
      r_paddr   <= w_nxtPaddr;
      r_pwdata  <= w_nxtPwdata;
      r_pwait   <= w_nxtPwait;
      r_owner   <= w_nxtOwner;
      r_cnt     <= w_nxtCnt;
      r_ack     <= w_nxtAck;
      r_err     <= w_nxtErr;
      r_rdata0  <= w_nxtRdata0;
      r_rdata1  <= w_nxtRdata1;
    end
  end

  assign apb.PSEL    = r_psel;
  assign apb.PENABLE = r_penable;
  assign apb.PWRITE  = r_pwrite;
  assign apb.PADDR   = r_paddr;
  assign apb.PWDATA  = r_pwdata;
  assign apb.PWAIT   = r_pwait;

  assign m0_ack   = r_ack[0];
  assign m1_ack   = r_ack[1];
  assign m0_err   = r_err[0];
  assign m1_err   = r_err[1];
  assign m0_rdata = r_rdata0;
  assign m1_rdata = r_rdata1;

endmodule
